// File: rtl/xvc_buffer_pkg.sv
// Shared sizing constants and types for the input- and output-side packet buffers.
package xvc_buffer_pkg;

  localparam int unsigned BUFFER_SIZE_O = 32;
  localparam int unsigned BUFFER_SIZE_I = 32;
  localparam int unsigned PACKET_SIZE   = 402;

  localparam int unsigned SIZE_BUFFER_SIZE_O = $clog2(BUFFER_SIZE_O);
  localparam int unsigned SIZE_BUFFER_SIZE_I = $clog2(BUFFER_SIZE_I);
  // Wide enough for a byte index and for a full-length count of PACKET_SIZE.
  localparam int unsigned SIZE_PACKET_SIZE   = $clog2(PACKET_SIZE + 1);
  localparam int unsigned SIZE_RAM_ADDR      = SIZE_BUFFER_SIZE_O + SIZE_PACKET_SIZE;

  typedef logic [7:0]                    TypeByte;
  typedef logic [SIZE_PACKET_SIZE-1:0]   TypePacketAddr;
  typedef logic [SIZE_BUFFER_SIZE_O-1:0] TypeBufferOAddr;
  typedef logic [SIZE_BUFFER_SIZE_O:0]   TypeBufferOCount;
  typedef logic [SIZE_RAM_ADDR-1:0]      TypeRamAddr;

  typedef enum logic [1:0] {
    ReaderIdle,
    ReaderFetch,
    ReaderStream
  } TypeReaderState;

endpackage

// File: rtl/packet_fifo_out_if.sv
// Write-side and transmit-side signals of the output packet FIFO.
interface packet_fifo_out_if;
  import xvc_buffer_pkg::*;

  logic            wr_open;
  logic            wr_en;
  TypePacketAddr   wr_addr;
  TypeByte         wr_data;
  logic            wr_commit;
  TypePacketAddr   wr_len;
  logic            wr_busy;
  logic            full;
  logic            empty;
  TypeBufferOCount count;
  logic            err;
  TypeByte         tx_data;
  logic            tx_valid;
  logic            tx_last;
  logic            tx_ready;

  modport master (
    output wr_open, wr_en, wr_addr, wr_data, wr_commit, tx_ready,
    input  wr_len, wr_busy, full, empty, count, err, tx_data, tx_valid, tx_last
  );

  modport slave (
    input  wr_open, wr_en, wr_addr, wr_data, wr_commit, tx_ready,
    output wr_len, wr_busy, full, empty, count, err, tx_data, tx_valid, tx_last
  );

endinterface

// File: rtl/packet_ram.sv
// Simple dual-port byte RAM: one synchronous write port, one synchronous read port.
module packet_ram
  import xvc_buffer_pkg::*;
(
  input  logic       clock,
  input  logic       wrEn,
  input  TypeRamAddr wrAddr,
  input  TypeByte    wrData,
  input  TypeRamAddr rdAddr,
  output TypeByte    rdData
);

  TypeByte mem [2**SIZE_RAM_ADDR];

  always_ff @(posedge clock) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/packet_fifo_out.sv
// Output packet FIFO: slots are filled and committed by the command engine,
// then streamed oldest-first as a valid/ready/last byte stream.
module packet_fifo_out
  import xvc_buffer_pkg::*;
(
  input logic             clock,
  input logic             reset,
  packet_fifo_out_if.slave bus
);

  TypeBufferOAddr  head;
  TypeBufferOAddr  tail;
  TypeBufferOCount count;
  logic            wrBusy;
  TypePacketAddr   wrLen;
  TypePacketAddr   lenArr [BUFFER_SIZE_O];
  logic            err;

  TypeReaderState  state;
  TypeReaderState  stateNext;
  TypePacketAddr   idx;
  TypePacketAddr   idxNext;
  TypePacketAddr   curLen;
  logic            retire;
  logic            txValid;
  logic            txLast;
  logic            handshake;
  TypeRamAddr      rdAddr;
  TypeByte         rdData;

  logic            full;
  logic            openOk;
  logic            enOk;
  logic            commitOk;
  TypePacketAddr   addrPlusOne;
  TypePacketAddr   lenNext;

  assign full        = (count + TypeBufferOCount'(wrBusy)) == TypeBufferOCount'(BUFFER_SIZE_O);
  assign openOk      = bus.wr_open && !full;
  assign enOk        = bus.wr_en && wrBusy && (bus.wr_addr < TypePacketAddr'(PACKET_SIZE));
  assign commitOk    = bus.wr_commit && wrBusy;
  assign addrPlusOne = bus.wr_addr + TypePacketAddr'(1);
  assign lenNext     = (enOk && (addrPlusOne > wrLen)) ? addrPlusOne : wrLen;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head   <= '0;
      wrBusy <= 1'b0;
      wrLen  <= '0;
      err    <= 1'b0;
    end else begin
      err <= (bus.wr_open && full) || (bus.wr_en && !enOk) || (bus.wr_commit && !wrBusy);
      if (commitOk) begin
        head   <= head + TypeBufferOAddr'(1);
        wrBusy <= openOk;
        wrLen  <= '0;
      end else if (openOk) begin
        wrBusy <= 1'b1;
        wrLen  <= '0;
      end else begin
        wrLen  <= lenNext;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (commitOk) begin
      lenArr[head] <= lenNext;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ReaderIdle;
      idx   <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      tail  <= tail + TypeBufferOAddr'(retire);
      count <= count + TypeBufferOCount'(commitOk) - TypeBufferOCount'(retire);
    end
  end

  // FETCH presents byte 0 straight from the RAM's registered output, so a
  // non-empty FETCH cycle is already a live beat and shares the STREAM logic.
  always_comb begin
    curLen    = lenArr[tail];
    txValid   = ((state == ReaderFetch) && (curLen != '0)) || (state == ReaderStream);
    handshake = txValid && bus.tx_ready;
    txLast    = txValid && (idx == curLen - TypePacketAddr'(1));
    stateNext = state;
    idxNext   = idx;
    retire    = 1'b0;
    rdAddr    = {tail, idx};
    case (state)
      ReaderIdle: begin
        idxNext = '0;
        rdAddr  = {tail, TypePacketAddr'(0)};
        if (count != '0) begin
          stateNext = ReaderFetch;
        end
      end
      ReaderFetch, ReaderStream: begin
        if (!txValid) begin
          retire    = 1'b1;
          stateNext = ReaderIdle;
        end else if (handshake) begin
          if (txLast) begin
            retire    = 1'b1;
            stateNext = ReaderIdle;
          end else begin
            idxNext   = idx + TypePacketAddr'(1);
            rdAddr    = {tail, idxNext};
            stateNext = ReaderStream;
          end
        end else begin
          stateNext = ReaderStream;
        end
      end
      default: stateNext = ReaderIdle;
    endcase
  end

  packet_ram u_ram (
    .clock  (clock),
    .wrEn   (enOk),
    .wrAddr ({head, bus.wr_addr}),
    .wrData (bus.wr_data),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  assign bus.wr_len   = wrLen;
  assign bus.wr_busy  = wrBusy;
  assign bus.full     = full;
  assign bus.empty    = (count == '0);
  assign bus.count    = count;
  assign bus.err      = err;
  assign bus.tx_valid = txValid;
  assign bus.tx_last  = txLast;
  assign bus.tx_data  = txValid ? rdData : '0;

endmodule

// File: tb/tb_packet_fifo_out.sv
// Directed bench for packet_fifo_out: streaming, ordering, backpressure, fill/wrap,
// request errors and mid-stream reset.
module tb_packet_fifo_out;
  import xvc_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  packet_fifo_out_if bus ();

  packet_fifo_out dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;
  int unsigned pktCount    = 0;

  int unsigned rxData [$];
  int unsigned rxLast [$];
  int unsigned rxCyc  [$];

  logic        prevStall = 1'b0;
  logic [7:0]  prevData  = '0;
  logic        prevLast  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkValue(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat monitor: records accepted bytes and checks stability across stalls.
  always @(negedge clock) begin
    if (reset && bus.tx_valid) begin
      if (prevStall) begin
        checkValue("holdData", bus.tx_data, prevData);
        checkValue("holdLast", bus.tx_last, prevLast);
      end
      if (bus.tx_ready) begin
        rxData.push_back(bus.tx_data);
        rxLast.push_back(bus.tx_last);
        rxCyc.push_back(cyc);
      end
    end
    prevStall = reset && bus.tx_valid && !bus.tx_ready;
    prevData  = bus.tx_data;
    prevLast  = bus.tx_last;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic openSlot();
    bus.wr_open = 1'b1;
    tick();
    bus.wr_open = 1'b0;
  endtask

  task automatic writeByte(input int unsigned addr, input int unsigned data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = TypePacketAddr'(addr);
    bus.wr_data = TypeByte'(data);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic commitSlot();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
    pktCount++;
  endtask

  task automatic writePacket(input int unsigned base, input int unsigned n);
    openSlot();
    for (int unsigned i = 0; i < n; i++) writeByte(i, base + i);
  endtask

  task automatic waitBeats(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (rxData.size() < target && n < budget) begin
      tick();
      n++;
    end
    checkValue(tag, rxData.size(), target);
  endtask

  task automatic checkBeats(input string tag, input int unsigned start, input int unsigned base,
                            input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned k = start + i;
      checkValue({tag, "Data"}, (k < rxData.size()) ? rxData[k] : 32'hDEAD, (base + i) & 8'hFF);
      checkValue({tag, "Last"}, (k < rxLast.size()) ? rxLast[k] : 32'hDEAD, (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned commitCyc;
    int unsigned n;
    logic found;

    bus.wr_open = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.wr_commit = 1'b0; bus.tx_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    checkValue("rstEmpty", bus.empty, 1);
    checkValue("rstFull", bus.full, 0);
    checkValue("rstCount", bus.count, 0);
    checkValue("rstBusy", bus.wr_busy, 0);
    checkValue("rstLen", bus.wr_len, 0);
    checkValue("rstValid", bus.tx_valid, 0);
    checkValue("rstLast", bus.tx_last, 0);
    checkValue("rstData", bus.tx_data, 0);
    checkValue("rstErr", bus.err, 0);
    @(negedge clock) reset = 1'b1;
    tick();

    // Packet 1: 8 bytes, sink always ready, two-cycle commit-to-valid latency.
    bus.tx_ready = 1'b1;
    writePacket(8'h2C, 8);
    checkValue("p1Len", bus.wr_len, 8);
    checkValue("p1Busy", bus.wr_busy, 1);
    base = rxData.size();
    commitSlot();
    commitCyc = cyc;
    checkValue("p1Count", bus.count, 1);
    checkValue("p1ValidEarly", bus.tx_valid, 0);
    waitBeats("p1Beats", base + 8, 30);
    checkBeats("p1", base, 8'h2C, 8);
    checkValue("p1Latency", (base < rxCyc.size()) ? rxCyc[base] : 0, commitCyc + 1);
    tick();
    checkValue("p1Drained", bus.count, 0);
    checkValue("p1Empty", bus.empty, 1);

    // Packets A and B queued behind a held-off sink, then released.
    bus.tx_ready = 1'b0;
    writePacket(8'hA0, 8);
    commitSlot();
    writePacket(8'h90, 4);
    commitSlot();
    repeat (3) tick();
    checkValue("abCount", bus.count, 2);
    checkValue("abHoldValid", bus.tx_valid, 1);
    checkValue("abHoldData", bus.tx_data, 8'hA0);
    base = rxData.size();
    bus.tx_ready = 1'b1;
    waitBeats("abBeats", base + 12, 60);
    checkBeats("pktA", base, 8'hA0, 8);
    checkBeats("pktB", base + 8, 8'h90, 4);
    checkValue("abGap", (base + 8 < rxCyc.size()) ? rxCyc[base + 8] - rxCyc[base + 7] : 0, 2);
    tick();
    checkValue("abDrained", bus.count, 0);

    // Backpressure: ready toggles every cycle.
    bus.tx_ready = 1'b0;
    writePacket(8'h50, 8);
    commitSlot();
    base = rxData.size();
    n = 0;
    while (rxData.size() < base + 8 && n < 60) begin
      bus.tx_ready = ~bus.tx_ready;
      tick();
      n++;
    end
    bus.tx_ready = 1'b1;
    repeat (10) tick();
    checkValue("bpBeats", rxData.size(), base + 8);
    checkBeats("bp", base, 8'h50, 8);
    checkValue("bpDrained", bus.count, 0);

    // Fill every slot with a 1-byte packet, then drain through the wrap.
    bus.tx_ready = 1'b0;
    for (int unsigned k = 0; k < BUFFER_SIZE_O; k++) begin
      writePacket(k, 1);
      commitSlot();
    end
    checkValue("fillFull", bus.full, 1);
    checkValue("fillCount", bus.count, BUFFER_SIZE_O);
    checkValue("fillEmpty", bus.empty, 0);
    openSlot();
    checkValue("fullOpenErr", bus.err, 1);
    checkValue("fullOpenBusy", bus.wr_busy, 0);
    tick();
    checkValue("errPulse", bus.err, 0);
    base = rxData.size();
    bus.tx_ready = 1'b1;
    waitBeats("drainBeats", base + BUFFER_SIZE_O, 120);
    for (int unsigned k = 0; k < BUFFER_SIZE_O; k++) checkBeats("drain", base + k, k, 1);
    tick();
    checkValue("drainCount", bus.count, 0);
    checkValue("headWrap", dut.head, pktCount % BUFFER_SIZE_O);
    checkValue("tailWrap", dut.tail, pktCount % BUFFER_SIZE_O);

    // Rejected requests, sparse write, reopen and zero-length commit.
    writeByte(0, 8'hEE);
    checkValue("enNoOpenErr", bus.err, 1);
    checkValue("enNoOpenBusy", bus.wr_busy, 0);
    checkValue("enNoOpenLen", bus.wr_len, 0);
    openSlot();
    writeByte(PACKET_SIZE, 8'h11);
    checkValue("addrMaxErr", bus.err, 1);
    checkValue("addrMaxLen", bus.wr_len, 0);
    writeByte(5, 8'h55);
    checkValue("sparseErr", bus.err, 0);
    checkValue("sparseLen", bus.wr_len, 6);
    openSlot();
    checkValue("reopenLen", bus.wr_len, 0);
    checkValue("reopenBusy", bus.wr_busy, 1);
    checkValue("reopenHead", dut.head, pktCount % BUFFER_SIZE_O);
    base = rxData.size();
    commitSlot();
    checkValue("zeroCount", bus.count, 1);
    repeat (8) tick();
    checkValue("zeroNoBeat", rxData.size(), base);
    checkValue("zeroDrained", bus.count, 0);
    checkValue("zeroEmpty", bus.empty, 1);
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
    checkValue("commitIdleErr", bus.err, 1);

    // Reset asserted while byte 3 of a packet is on the bus.
    bus.tx_ready = 1'b1;
    writePacket(8'h70, 8);
    commitSlot();
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      if (bus.tx_valid && bus.tx_data == 8'h72) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    checkValue("rstReach", found, 1);
    #2 reset = 1'b0;
    #1;
    checkValue("midRstValid", bus.tx_valid, 0);
    checkValue("midRstCount", bus.count, 0);
    checkValue("midRstEmpty", bus.empty, 1);
    checkValue("midRstData", bus.tx_data, 0);
    pktCount = 0;
    @(negedge clock) reset = 1'b1;
    tick();
    base = rxData.size();
    writePacket(8'h11, 3);
    commitSlot();
    waitBeats("postRstBeats", base + 3, 30);
    checkBeats("postRst", base, 8'h11, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
